// File: rtl/dbg_reg_arb_pkg.sv
// Shared debug definitions: FSM encodings, default widths and timeout, arbitration helper.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package dbg_reg_arb_pkg;

    // Widths of the core debug register interface.
    localparam int DBG_DATA_W      = 32;
    localparam int DBG_REGNO_W     = 16;

    // Access watchdog: default cycle budget and counter width.
    localparam int DBG_TIMEOUT_CYC = 256;
    localparam int DBG_TO_W        = 16;

    // Transaction sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } dbg_state_e;

    // Two-way round-robin pick. A lone requester always wins. Under contention the
    // requester that was not served last wins. last_grant is the index of the
    // previous winner. The result is one-hot, or zero when nobody requests.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_grant);
        logic [1:0] gnt;
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_grant ? 2'b01 : 2'b10;
        end
        return gnt;
    endfunction

endpackage

// File: rtl/dbg_rr_arb2.sv
// Two-input round-robin grant with a last-winner register updated on acceptance.
// Latency: grant is combinational from req_i; history updates on the clock after upd_i.
// Backpressure: none internally; the caller qualifies the grant with its own ready condition.
module dbg_rr_arb2
    import dbg_reg_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;

    // Combinational grant from the current requests and the previous winner.
    always_comb begin
        gnt_o = rr_pick(req_i, last_q);
    end

    // Remember the winner only when its transaction is actually accepted.
    always_comb begin
        last_d = last_q;
        if (upd_i) begin
            last_d = gnt_o[1];
        end
    end

    // Reset to 1 so that requester 0 wins the first contention.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/dbg_reg_arb.sv
// Arbitrates two debug requesters onto the core's single debug register port, one transaction at a time.
// Latency: accept at N -> access from N+1; completion at M -> response at M+1 (3-cycle minimum round trip).
// Backpressure: requesters see ready only in IDLE; a held response stalls everything until the owner takes it.
module dbg_reg_arb
    import dbg_reg_arb_pkg::*;
#(
    parameter int DATA_W      = DBG_DATA_W,
    parameter int REGNO_W     = DBG_REGNO_W,
    parameter int TIMEOUT_CYC = DBG_TIMEOUT_CYC,
    parameter int TO_W        = DBG_TO_W
) (
    input  logic               sys_clk,
    input  logic               sys_rst,

    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic               req0_wr1_rd0,
    input  logic [REGNO_W-1:0] req0_regno,
    input  logic [DATA_W-1:0]  req0_wdata,
    output logic               rsp0_valid,
    input  logic               rsp0_ready,
    output logic [DATA_W-1:0]  rsp0_data,
    output logic               rsp0_err,

    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic               req1_wr1_rd0,
    input  logic [REGNO_W-1:0] req1_regno,
    input  logic [DATA_W-1:0]  req1_wdata,
    output logic               rsp1_valid,
    input  logic               rsp1_ready,
    output logic [DATA_W-1:0]  rsp1_data,
    output logic               rsp1_err,

    output logic               dbg_reg_access,
    output logic               dbg_wr1_rd0,
    output logic [REGNO_W-1:0] dbg_regno,
    output logic [DATA_W-1:0]  dbg_write_data,
    input  logic               dbg_read_data_valid,
    input  logic [DATA_W-1:0]  dbg_read_data
);

    // Counter value on the last cycle of ACCESS before the watchdog fires.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    dbg_state_e         state_q, state_d;
    logic               wr_q, wr_d;
    logic [REGNO_W-1:0] regno_q, regno_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               owner_q, owner_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;
    logic [TO_W-1:0]    cnt_q, cnt_d;

    logic [1:0]         gnt;
    logic               acc0;
    logic               acc1;
    logic               owner_rsp_rdy;

    // Readies depend only on state and the request valids, never on rsp_ready.
    assign req0_ready = (state_q == ST_IDLE) & gnt[0];
    assign req1_ready = (state_q == ST_IDLE) & gnt[1];
    assign acc0       = req0_valid & req0_ready;
    assign acc1       = req1_valid & req1_ready;

    dbg_rr_arb2 u_rr (
        .clk_i (sys_clk),
        .rst_i (sys_rst),
        .req_i ({req1_valid, req0_valid}),
        .upd_i (acc0 | acc1),
        .gnt_o (gnt)
    );

    assign owner_rsp_rdy = owner_q ? rsp1_ready : rsp0_ready;

    // Next-state logic: capture on acceptance, wait for completion or timeout, hold the response.
    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        regno_d    = regno_q;
        wdata_d    = wdata_q;
        owner_d    = owner_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (acc0 | acc1) begin
                    owner_d = acc1;
                    wr_d    = acc1 ? req1_wr1_rd0 : req0_wr1_rd0;
                    regno_d = acc1 ? req1_regno   : req0_regno;
                    wdata_d = acc1 ? req1_wdata   : req0_wdata;
                    cnt_d   = '0;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Completion takes priority over a timeout landing in the same cycle.
                if (dbg_read_data_valid) begin
                    rsp_data_d = wr_q ? '0 : dbg_read_data;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_RESP;
                end else if (cnt_q == TO_LAST) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            ST_RESP: begin
                // Late core completions are ignored here; the response stays frozen.
                if (owner_rsp_rdy) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, captured request fields, response and watchdog registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= ST_IDLE;
            wr_q       <= 1'b0;
            regno_q    <= '0;
            wdata_q    <= '0;
            owner_q    <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            regno_q    <= regno_d;
            wdata_q    <= wdata_d;
            owner_q    <= owner_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            cnt_q      <= cnt_d;
        end
    end

    // Core port: the strobe follows the registered state, so reset drops it asynchronously.
    assign dbg_reg_access = (state_q == ST_ACCESS);
    assign dbg_wr1_rd0    = wr_q;
    assign dbg_regno      = regno_q;
    assign dbg_write_data = wdata_q;

    // Response mux: only the owner sees valid; the other side reads all zeros.
    assign rsp0_valid = (state_q == ST_RESP) & ~owner_q;
    assign rsp1_valid = (state_q == ST_RESP) &  owner_q;
    assign rsp0_data  = rsp0_valid ? rsp_data_q : '0;
    assign rsp1_data  = rsp1_valid ? rsp_data_q : '0;
    assign rsp0_err   = rsp0_valid & rsp_err_q;
    assign rsp1_err   = rsp1_valid & rsp_err_q;

endmodule

// File: tb/tb_dbg_reg_arb.sv
// Directed bench for dbg_reg_arb: read, write, contention, timeout, backpressure, async reset.
module tb_dbg_reg_arb;

    logic        sys_clk;
    logic        sys_rst;
    logic        req0_valid, req0_ready, req0_wr1_rd0;
    logic [15:0] req0_regno;
    logic [31:0] req0_wdata;
    logic        rsp0_valid, rsp0_ready, rsp0_err;
    logic [31:0] rsp0_data;
    logic        req1_valid, req1_ready, req1_wr1_rd0;
    logic [15:0] req1_regno;
    logic [31:0] req1_wdata;
    logic        rsp1_valid, rsp1_ready, rsp1_err;
    logic [31:0] rsp1_data;
    logic        dbg_reg_access, dbg_wr1_rd0;
    logic [15:0] dbg_regno;
    logic [31:0] dbg_write_data;
    logic        dbg_read_data_valid;
    logic [31:0] dbg_read_data;

    int n_chk = 0;
    int n_err = 0;

    dbg_reg_arb #(.TIMEOUT_CYC(8)) dut (
        .sys_clk             (sys_clk),
        .sys_rst             (sys_rst),
        .req0_valid          (req0_valid),
        .req0_ready          (req0_ready),
        .req0_wr1_rd0        (req0_wr1_rd0),
        .req0_regno          (req0_regno),
        .req0_wdata          (req0_wdata),
        .rsp0_valid          (rsp0_valid),
        .rsp0_ready          (rsp0_ready),
        .rsp0_data           (rsp0_data),
        .rsp0_err            (rsp0_err),
        .req1_valid          (req1_valid),
        .req1_ready          (req1_ready),
        .req1_wr1_rd0        (req1_wr1_rd0),
        .req1_regno          (req1_regno),
        .req1_wdata          (req1_wdata),
        .rsp1_valid          (rsp1_valid),
        .rsp1_ready          (rsp1_ready),
        .rsp1_data           (rsp1_data),
        .rsp1_err            (rsp1_err),
        .dbg_reg_access      (dbg_reg_access),
        .dbg_wr1_rd0         (dbg_wr1_rd0),
        .dbg_regno           (dbg_regno),
        .dbg_write_data      (dbg_write_data),
        .dbg_read_data_valid (dbg_read_data_valid),
        .dbg_read_data       (dbg_read_data)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Step to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_n;
        int w;
        int bad;
        logic r1_seen;
        logic gnt1;

        sys_rst = 1'b1;
        req0_valid = 0; req0_wr1_rd0 = 0; req0_regno = '0; req0_wdata = '0; rsp0_ready = 0;
        req1_valid = 0; req1_wr1_rd0 = 0; req1_regno = '0; req1_wdata = '0; rsp1_ready = 0;
        dbg_read_data_valid = 0; dbg_read_data = '0;

        // Reset state
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst_access", dbg_reg_access, 0);
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp1_valid", rsp1_valid, 0);
        chk("rst_regno", dbg_regno, 0);
        chk("rst_wdata", dbg_write_data, 0);
        chk("rst_wr", dbg_wr1_rd0, 0);
        sys_rst = 1'b0;
        tick();

        // Single read by req0, core answers after 3 access cycles
        req0_valid = 1; req0_wr1_rd0 = 0; req0_regno = 16'h1001; req0_wdata = 32'h1111_1111;
        settle();
        chk("t1_req0_ready", req0_ready, 1);
        chk("t1_req1_ready", req1_ready, 0);
        tick();
        req0_valid = 0; req0_regno = 16'hFFFF;
        settle();
        chk("t1_regno", dbg_regno, 16'h1001);
        chk("t1_dir", dbg_wr1_rd0, 0);
        acc_n = 0;
        r1_seen = 0;
        for (int i = 0; i < 3; i++) begin
            if (dbg_reg_access) acc_n++;
            if (rsp1_valid) r1_seen = 1;
            if (i == 2) begin
                dbg_read_data_valid = 1;
                dbg_read_data = 32'hDEAD_BEEF;
            end
            tick();
        end
        dbg_read_data_valid = 0; dbg_read_data = '0;
        settle();
        chk("t1_access_cycles", acc_n, 3);
        chk("t1_access_off", dbg_reg_access, 0);
        chk("t1_rsp0_valid", rsp0_valid, 1);
        chk("t1_rsp0_data", rsp0_data, 32'hDEAD_BEEF);
        chk("t1_rsp0_err", rsp0_err, 0);
        if (rsp1_valid) r1_seen = 1;
        rsp0_ready = 1;
        tick();
        rsp0_ready = 0;
        settle();
        chk("t1_rsp0_done", rsp0_valid, 0);
        chk("t1_rsp1_never", r1_seen, 0);

        // Write by req1, core completes in the first access cycle
        req1_valid = 1; req1_wr1_rd0 = 1; req1_regno = 16'h1002; req1_wdata = 32'h1234_5678;
        rsp1_ready = 1;
        settle();
        chk("t2_req1_ready", req1_ready, 1);
        tick();
        req1_valid = 0; req1_wdata = '0;
        dbg_read_data_valid = 1; dbg_read_data = 32'hFFFF_FFFF;
        settle();
        chk("t2_access", dbg_reg_access, 1);
        chk("t2_dir", dbg_wr1_rd0, 1);
        chk("t2_wdata", dbg_write_data, 32'h1234_5678);
        chk("t2_regno", dbg_regno, 16'h1002);
        tick();
        dbg_read_data_valid = 0;
        settle();
        chk("t2_access_off", dbg_reg_access, 0);
        chk("t2_rsp1_valid", rsp1_valid, 1);
        chk("t2_rsp1_data", rsp1_data, 0);
        chk("t2_rsp1_err", rsp1_err, 0);
        chk("t2_rsp0_valid", rsp0_valid, 0);
        tick();
        settle();
        chk("t2_rt_rsp_off", rsp1_valid, 0);
        chk("t2_rt_access_off", dbg_reg_access, 0);
        rsp1_ready = 0;

        // Contention: both valid continuously, grants alternate starting with req0
        rsp0_ready = 1; rsp1_ready = 1;
        req0_wr1_rd0 = 0; req0_regno = 16'h2000;
        req1_wr1_rd0 = 0; req1_regno = 16'h2001;
        req0_valid = 1; req1_valid = 1;
        dbg_read_data_valid = 1;
        for (int i = 0; i < 8; i++) begin
            dbg_read_data = 32'hC0DE_0000 + i;
            settle();
            w = 0;
            while (!(req0_ready | req1_ready) && w < 10) begin
                tick();
                w++;
            end
            chk("t3_wait_ready", (w < 10), 1);
            gnt1 = req1_ready;
            chk("t3_grant", gnt1, i % 2);
            tick();
            if (i == 7) begin
                req0_valid = 0; req1_valid = 0;
            end
            settle();
            chk("t3_regno", dbg_regno, 16'h2000 + gnt1);
            tick();
            settle();
            if (gnt1) begin
                chk("t3_rsp1_valid", rsp1_valid, 1);
                chk("t3_rsp1_data", rsp1_data, 32'hC0DE_0000 + i);
            end else begin
                chk("t3_rsp0_valid", rsp0_valid, 1);
                chk("t3_rsp0_data", rsp0_data, 32'hC0DE_0000 + i);
            end
            tick();
        end
        dbg_read_data_valid = 0; dbg_read_data = '0;
        rsp0_ready = 0; rsp1_ready = 0;

        // Timeout: core never completes
        req0_valid = 1; req0_wr1_rd0 = 0; req0_regno = 16'h3000;
        settle();
        chk("t4_req0_ready", req0_ready, 1);
        tick();
        req0_valid = 0;
        settle();
        acc_n = 0;
        while (dbg_reg_access && acc_n < 20) begin
            acc_n++;
            tick();
        end
        chk("t4_access_cycles", acc_n, 8);
        chk("t4_rsp0_valid", rsp0_valid, 1);
        chk("t4_rsp0_err", rsp0_err, 1);
        chk("t4_rsp0_data", rsp0_data, 0);
        dbg_read_data_valid = 1; dbg_read_data = 32'h5555_5555;
        tick();
        dbg_read_data_valid = 0;
        settle();
        chk("t4_late_valid", rsp0_valid, 1);
        chk("t4_late_data", rsp0_data, 0);
        chk("t4_late_err", rsp0_err, 1);
        rsp0_ready = 1;
        tick();
        rsp0_ready = 0;
        dbg_read_data_valid = 1;
        tick();
        dbg_read_data_valid = 0;
        settle();
        chk("t4_idle_access", dbg_reg_access, 0);
        chk("t4_idle_rsp", rsp0_valid, 0);
        req0_valid = 1; req0_regno = 16'h3004;
        settle();
        chk("t4b_req0_ready", req0_ready, 1);
        tick();
        req0_valid = 0;
        tick();
        dbg_read_data_valid = 1; dbg_read_data = 32'hA5A5_A5A5;
        tick();
        dbg_read_data_valid = 0; dbg_read_data = '0;
        settle();
        chk("t4b_rsp0_valid", rsp0_valid, 1);
        chk("t4b_rsp0_data", rsp0_data, 32'hA5A5_A5A5);
        chk("t4b_rsp0_err", rsp0_err, 0);

        // Response backpressure: hold rsp0_ready low for 10 cycles
        req1_valid = 1; req1_wr1_rd0 = 1; req1_regno = 16'h4000; req1_wdata = 32'h0000_BEEF;
        settle();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!rsp0_valid || rsp0_data !== 32'hA5A5_A5A5 || rsp0_err || req1_ready || dbg_reg_access)
                bad++;
            tick();
        end
        chk("t5_stall_violations", bad, 0);
        chk("t5_req1_blocked", req1_ready, 0);
        rsp0_ready = 1;
        tick();
        rsp0_ready = 0;
        settle();
        chk("t5_req1_ready_after", req1_ready, 1);

        // Reset mid-ACCESS: strobe drops without a clock edge; req0 wins contention afterwards
        req1_valid = 0;
        req0_valid = 1; req0_regno = 16'h5000;
        settle();
        chk("t6_req0_ready", req0_ready, 1);
        tick();
        req0_valid = 0;
        settle();
        chk("t6_access_on", dbg_reg_access, 1);
        chk("t6_regno", dbg_regno, 16'h5000);
        #2;
        sys_rst = 1;
        #1;
        chk("t6_async_access", dbg_reg_access, 0);
        chk("t6_async_regno", dbg_regno, 0);
        chk("t6_async_rsp0", rsp0_valid, 0);
        tick();
        sys_rst = 0;
        req0_valid = 1; req1_valid = 1;
        settle();
        chk("t6_post_req0_ready", req0_ready, 1);
        chk("t6_post_req1_ready", req1_ready, 0);
        req0_valid = 0; req1_valid = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
